// File: rtl/add_seq_32.sv
// Sequential 32-bit adder: time-multiplexes an external 8-bit adder over four
// byte cycles, least significant byte first, chaining the carry in a register.
module add_seq_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_y,
    input  logic        add_co,
    output logic        busy,
    output logic        done,
    output logic [31:0] y,
    output logic        co,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        cin_reg;
    logic        carry;
    logic [23:0] sum_lo;
    logic [4:0]  bit_ofs;

    assign bit_ofs = {idx, 3'b000};

    // Byte lanes are selected straight from the captured operands so the
    // external adder sees stable inputs for the whole ADD cycle.
    always_comb begin
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        if (state == ADD) begin
            add_a   = a_reg[bit_ofs +: 8];
            add_b   = b_reg[bit_ofs +: 8];
            add_cin = (idx == 2'd0) ? cin_reg : carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            cin_reg <= 1'b0;
            carry   <= 1'b0;
            sum_lo  <= 24'd0;
            y       <= 32'd0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        cin_reg <= cin;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    carry <= add_co;
                    case (idx)
                        2'd0: sum_lo[7:0]   <= add_y;
                        2'd1: sum_lo[15:8]  <= add_y;
                        2'd2: sum_lo[23:16] <= add_y;
                        default: begin
                            // Final byte: publish the whole result at once so y,
                            // co and ovf only ever change together with done.
                            y     <= {add_y, sum_lo};
                            co    <= add_co;
                            ovf   <= (a_reg[31] == b_reg[31]) && (add_y[7] != a_reg[31]);
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    endcase
                    if (idx != 2'd3) begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    idx   <= 2'd0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_32.sv
// Scoreboard bench for add_seq_32 with a bit-level 8-bit ripple-carry adder on
// the add_* port.
`timescale 1ns/1ps
module tb_add_seq_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_y;
    logic        add_co;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        co;
    logic        ovf;

    typedef struct packed {
        logic [31:0] y;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   errors       = 0;
    int   done_count   = 0;
    int   expected_ops = 0;
    int   cyc          = 0;

    add_seq_32 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_cin(add_cin),
        .add_y  (add_y),
        .add_co (add_co),
        .busy   (busy),
        .done   (done),
        .y      (y),
        .co     (co),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 8-bit ripple-carry adder
    always_comb begin
        logic       c;
        logic [7:0] s;
        c = add_cin;
        s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            s[i] = add_a[i] ^ add_b[i] ^ c;
            c    = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
        end
        add_y  = s;
        add_co = c;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got y=0x%0h with no operation outstanding", y);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_y", {32'd0, y}, {32'd0, e.y});
                chk("result_co", {63'd0, co}, {63'd0, e.co});
                chk("result_ovf", {63'd0, ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                          input logic [31:0] ey, input logic eco, input logic eovf,
                          input bit check_cin);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        exp_q.push_back('{y: ey, co: eco, ovf: eovf});
        expected_ops++;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk("busy_in_add", {63'd0, busy}, 64'd1);
        if (check_cin) chk("add_cin_byte0", {63'd0, add_cin}, {63'd0, tc});
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (check_cin && lat <= 4) chk("add_cin_carry", {63'd0, add_cin}, 64'd1);
        end
        chk("latency", lat, 5);
        chk("busy_on_done", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("done_single", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int seen;
        reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y", {32'd0, y}, 64'd0);
        chk("rst_flags", {61'd0, co, ovf, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_add_bus", {47'd0, add_a, add_b, add_cin}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        run_op(32'h9C9C_9C9C, 32'hFFFF_FFFF, 1'b0, 32'h9C9C_9C9B, 1'b1, 1'b0, 1'b0);
        chk("idle_add_bus", {47'd0, add_a, add_b, add_cin}, 64'd0);

        // Abort mid-operation at byte index 2; no expectation is queued
        @(negedge clk);
        a = 32'h0102_0304; b = 32'h1020_3040; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_byte2_a", {56'd0, add_a}, 64'h02);
        reset = 1'b1;
        #1;
        chk("abort_y", {32'd0, y}, 64'd0);
        chk("abort_flags", {60'd0, co, ovf, done, busy}, 64'd0);
        chk("abort_add_bus", {47'd0, add_a, add_b, add_cin}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_op(32'd3, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);

        // start and a disturbed while busy: operands must not change
        @(negedge clk);
        a = 32'h0000_00C8; b = 32'h0000_0064; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{y: 32'h0000_012C, co: 1'b0, ovf: 1'b0});
        expected_ops++;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        while (!done && seen < 10) begin
            @(negedge clk);
            seen++;
        end
        chk("busy_prot_done_seen", {63'd0, done}, 64'd1);
        repeat (4) @(negedge clk);
        chk("busy_prot_idle", {63'd0, busy}, 64'd0);

        // start held high: back-to-back operations with one IDLE cycle between
        @(negedge clk);
        a = 32'd5; b = 32'd6; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{y: 32'd11, co: 1'b0, ovf: 1'b0});
        exp_q.push_back('{y: 32'd11, co: 1'b0, ovf: 1'b0});
        expected_ops += 2;
        seen = 0; t0 = 0; t1 = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            @(negedge clk);
            if (done) begin
                if (seen == 0) t0 = cyc; else t1 = cyc;
                seen++;
            end
        end
        start = 1'b0;
        chk("b2b_count", seen, 2);
        chk("b2b_interval", t1 - t0, 6);

        repeat (8) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_pulses", done_count, expected_ops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_seq_32.md
ADD_SEQ_32 -- requirements
Module: add_seq_32

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  32  operand A; captured on accepted start.
REQ-006 b  input  32  operand B; captured on accepted start.
REQ-007 cin  input  1  carry-in; captured on accepted start.
REQ-008 add_a  output  8  byte of A driven to the external 8-bit ripple adder.
REQ-009 add_b  output  8  byte of B driven to the external 8-bit adder.
REQ-010 add_cin  output  1  carry driven to the external 8-bit adder.
REQ-011 add_y  input  8  combinational sum returned by the external adder.
REQ-012 add_co  input  1  combinational carry-out returned by the external adder.
REQ-013 busy  output  1  high while in ADD or DONE.
REQ-014 done  output  1  single-cycle pulse; y, co and ovf are valid.
REQ-015 y  output  32  registered 32-bit sum.
REQ-016 co  output  1  registered carry-out of bit 31.
REQ-017 ovf  output  1  registered two's-complement overflow.

Function
REQ-018 SHALL implement FSM states IDLE, ADD, DONE, with a 2-bit byte index idx (0..3).
REQ-019 IDLE: start=1 at a rising edge SHALL capture a, b and cin into internal registers, set idx=0 and enter ADD; start=0 SHALL stay in IDLE.
REQ-020 ADD drive rules (combinational, from registers):
  - add_a = A_reg[8*idx+7 : 8*idx]; add_b = B_reg[8*idx+7 : 8*idx].
  - add_cin = captured cin when idx=0; otherwise the carry register.
REQ-021 ADD capture: each rising edge SHALL write add_y into result byte idx and add_co into the carry register, then increment idx.
REQ-022 Leaving ADD: when idx=3 at the capture edge, the FSM SHALL move to DONE instead of incrementing.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 co SHALL equal the carry captured from byte 3.
REQ-025 ovf SHALL equal (A_reg[31]==B_reg[31]) && (y[31]!=A_reg[31]).
REQ-026 Latency: start accepted at edge k -> ADD for the four cycles following k -> done high for the cycle after edge k+4; busy high over that whole five-cycle window.
REQ-027 start SHALL be ignored while busy=1; captured operands SHALL NOT change mid-operation even if a, b or cin change.
REQ-028 y, co and ovf SHALL hold their values from done until the next done; partial bytes are not guaranteed stable while busy.
REQ-029 start held high continuously SHALL give back-to-back operations, with one IDLE cycle between done and the next ADD.
REQ-030 Outside ADD, add_a, add_b and add_cin SHALL drive 0.
REQ-031 Arithmetic SHALL be unsigned modulo 2^32, so {co,y} = a + b + cin exactly.

Reset
REQ-032 Asserting reset SHALL immediately force: state IDLE, idx=0, carry=0, operand registers 0, y=0, co=0, ovf=0, done=0, busy=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL run normally.

Verification
REQ-034 Bench SHALL instantiate add_seq_32 with the team's existing 8-bit ripple-carry adder on the add_* ports.
REQ-035 Basic add: a=0x00000001, b=0x00000001, cin=0 -> done five cycles after start; y=0x00000002, co=0, ovf=0.
REQ-036 Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1 -> y=0x00000000, co=1, ovf=0; bytes 1..3 take add_cin=1.
REQ-037 Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> y=0x80000000, co=0, ovf=1. Second case: a=0x9C9C9C9C, b=0xFFFFFFFF -> y=0x9C9C9C9B, co=1, ovf=0.
REQ-038 Busy protection: start pulsed again, and a changed to 0x12345678, during ADD of a=0xC8, b=0x64 -> y=0x0000012C and only one done pulse.
REQ-039 Reset mid-op: reset asserted in ADD with idx=2 -> all outputs 0 at once, no done pulse; a new start with a=3, b=3 -> y=6.
